// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                forward-select encodings, multicycle FSM state type, the
//                PC register index and a register-compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Operand source selects for the Execute-stage muxes
    localparam logic [1:0] FWD_RF = 2'b00;  // register file
    localparam logic [1:0] FWD_W  = 2'b01;  // Writeback result
    localparam logic [1:0] FWD_M  = 2'b10;  // Memory-stage ALU result

    // R15 is the PC; it is never produced by the pipeline, so it never matches
    localparam logic [3:0] PC_IDX = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
        return (a == b) && (a != PC_IDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mcycle_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_fsm
//  Description : Tracks the multicycle execution unit (IDLE/BUSY/DONE) with a
//                watchdog that forces completion after MC_MAX_CYCLES BUSY
//                cycles and flags that case with a one-cycle timeout pulse.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_p (async, active-high)
//                i_start   - multicycle op issued from Execute
//                i_done    - unit reports completion
//                o_busy    - FSM is in BUSY
//                o_timeout - high for the DONE cycle after a watchdog exit
// ============================================================================
module mcycle_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_p,
    input  logic i_start,
    input  logic i_done,
    output logic o_busy,
    output logic o_timeout
);

    localparam int CW = (MC_MAX_CYCLES > 1) ? $clog2(MC_MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MC_MAX_CYCLES - 1);

    mc_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          tout_q,  tout_d;   // last BUSY exit was the watchdog

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
                end
            end
            BUSY: begin
                if (i_done || (cnt_q == LIMIT)) begin
                    state_d = DONE;
                    // a real completion on the limit cycle is not a timeout
                    tout_d  = !i_done;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // start requests here are dropped on purpose
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy    = (state_q == BUSY);
    assign o_timeout = (state_q == DONE) && tout_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard unit: operand forwarding, load-use and
//                branch handling, and stalls for a multicycle Execute unit.
//                Priority: multicycle stall > taken branch > data hazard.
//  Revision    : 1.0 - initial release
//  Config      : HAZARD_FWD_EN - when defined, forwarding is enabled and only
//                loads stall; otherwise forward selects are 0 and any
//                in-flight E/M write to a Decode source stalls.
//  Ports       : clk, rst_p (async, active-high)
//                RA1_D/RA2_D, RA1_E/RA2_E, RA2_M  - source registers
//                WA3_E/M/W, RegWrite_E/M/W        - destinations / enables
//                MemtoReg_E, PCSrc_E, MStart_E, MDone
//                StallF/D/E, FlushD/E             - pipeline control
//                ForwardAE/BE, ForwardM           - forward selects
//                MBusy, MTimeout, StallCount      - status
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic [3:0]  RA1_D,
    input  logic [3:0]  RA2_D,
    input  logic [3:0]  RA1_E,
    input  logic [3:0]  RA2_E,
    input  logic [3:0]  RA2_M,
    input  logic [3:0]  WA3_E,
    input  logic [3:0]  WA3_M,
    input  logic [3:0]  WA3_W,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic        RegWrite_W,
    input  logic        MemtoReg_E,
    input  logic        PCSrc_E,
    input  logic        MStart_E,
    input  logic        MDone,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardM,
    output logic        MBusy,
    output logic        MTimeout,
    output logic [15:0] StallCount
);

    logic        mc_busy;
    logic        mc_timeout;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        fwd_m;
    logic        data_stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    mcycle_fsm #(
        .MC_MAX_CYCLES (MC_MAX_CYCLES)
    ) u_mcycle_fsm (
        .clk       (clk),
        .rst_p     (rst_p),
        .i_start   (MStart_E),
        .i_done    (MDone),
        .o_busy    (mc_busy),
        .o_timeout (mc_timeout)
    );

`ifdef HAZARD_FWD_EN
    always_comb begin
        fwd_a = FWD_RF;
        if (RegWrite_M && reg_match(WA3_M, RA1_E))      fwd_a = FWD_M;
        else if (RegWrite_W && reg_match(WA3_W, RA1_E)) fwd_a = FWD_W;

        fwd_b = FWD_RF;
        if (RegWrite_M && reg_match(WA3_M, RA2_E))      fwd_b = FWD_M;
        else if (RegWrite_W && reg_match(WA3_W, RA2_E)) fwd_b = FWD_W;

        fwd_m = RegWrite_W && reg_match(WA3_W, RA2_M);

        // only a load result is too late to forward into the next op
        data_stall = MemtoReg_E && RegWrite_E &&
                     (reg_match(WA3_E, RA1_D) || reg_match(WA3_E, RA2_D));
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{RA1_E, RA2_E, RA2_M, WA3_W, RegWrite_W, MemtoReg_E};

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        fwd_m = 1'b0;
        // without bypass paths, wait until the producer has left M
        data_stall = (RegWrite_E && (reg_match(WA3_E, RA1_D) || reg_match(WA3_E, RA2_D))) ||
                     (RegWrite_M && (reg_match(WA3_M, RA1_D) || reg_match(WA3_M, RA2_D)));
    end
`endif

    // Outputs are forced low while reset is asserted, independent of inputs
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardM  = 1'b0;
        if (!rst_p) begin
            if (mc_busy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (PCSrc_E) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (data_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            ForwardM  = fwd_m;
        end
    end

    assign MBusy    = mc_busy;
    assign MTimeout = mc_timeout;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Expected output vectors
//                {flags, StallCount} are queued as stimulus is applied and
//                compared against the DUT mid-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // flag vector order: StallF StallD StallE FlushD FlushE AE[1:0] BE[1:0] M Busy Tout
    localparam logic [11:0] NONE  = 12'h000;
    localparam logic [11:0] LU    = 12'hC80;  // StallF, StallD, FlushE
    localparam logic [11:0] BR    = 12'h180;  // FlushD, FlushE
    localparam logic [11:0] BUSYV = 12'hE02;  // StallF/D/E, MBusy
    localparam logic [11:0] TOUT  = 12'h001;  // MTimeout

    logic        clk = 1'b0;
    logic        rst_p;
    logic [3:0]  RA1_D, RA2_D, RA1_E, RA2_E, RA2_M, WA3_E, WA3_M, WA3_W;
    logic        RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, PCSrc_E, MStart_E, MDone;
    logic        StallF, StallD, StallE, FlushD, FlushE, ForwardM, MBusy, MTimeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_MAX_CYCLES(32)) dut (
        .clk(clk), .rst_p(rst_p),
        .RA1_D(RA1_D), .RA2_D(RA2_D), .RA1_E(RA1_E), .RA2_E(RA2_E), .RA2_M(RA2_M),
        .WA3_E(WA3_E), .WA3_M(WA3_M), .WA3_W(WA3_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .PCSrc_E(PCSrc_E), .MStart_E(MStart_E), .MDone(MDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
        .MBusy(MBusy), .MTimeout(MTimeout), .StallCount(StallCount)
    );

    logic [11:0] obs;
    assign obs = {StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE,
                  ForwardM, MBusy, MTimeout};

    logic [27:0] sb[$];
    logic [15:0] exp_cnt;
    logic [27:0] got, expv;
    int checks = 0;
    int errors = 0;

    function automatic logic [11:0] mk_fwd(input logic [1:0] fae, input logic [1:0] fbe,
                                           input logic fm);
        return {5'b0, fae, fbe, fm, 2'b0};
    endfunction

    // Queue the expectation for this cycle; the counter model advances at the next edge
    task automatic push(input logic [11:0] f);
        sb.push_back({f, exp_cnt});
        if (f[11] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic clear_inputs();
        RA1_D = 0; RA2_D = 0; RA1_E = 0; RA2_E = 0; RA2_M = 0;
        WA3_E = 0; WA3_M = 0; WA3_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemtoReg_E = 0; PCSrc_E = 0; MStart_E = 0; MDone = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 5; RA2_D = 5; PCSrc_E = 1;
                    RegWrite_M = 1; WA3_M = 3; RA1_E = 3; RegWrite_W = 1; WA3_W = 7; RA2_M = 7;
                end
                1: MStart_E = 1;
                default: rst_p = 0;
            endcase
            push(NONE);
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL reset[%0d]: got %h exp %h", i, got, expv);
            end
            next_cycle();
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    RegWrite_M = 1; WA3_M = 3; RA1_E = 3; RegWrite_W = 1; WA3_W = 3;
                    push(mk_fwd(FWD ? 2'b10 : 2'b00, 2'b00, 1'b0));
                end
                1: begin
                    RegWrite_M = 0; WA3_M = 3; RA1_E = 3; RegWrite_W = 1; WA3_W = 3;
                    push(mk_fwd(FWD ? 2'b01 : 2'b00, 2'b00, 1'b0));
                end
                2: begin
                    RegWrite_W = 1; WA3_W = 7; RA2_E = 7; RA2_M = 7;
                    push(mk_fwd(2'b00, FWD ? 2'b01 : 2'b00, FWD));
                end
                3: begin
                    RegWrite_M = 1; RegWrite_W = 1; WA3_M = 15; WA3_W = 15;
                    RA1_E = 15; RA2_E = 15; RA2_M = 15;
                    push(NONE);
                end
                default: begin
                    RegWrite_M = 1; WA3_M = 4; RegWrite_W = 1; WA3_W = 4; RA1_E = 4; RA2_E = 4;
                    push(mk_fwd(FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 1'b0));
                end
            endcase
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL forward[%0d]: got %h exp %h", i, got, expv);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: begin MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 5; RA2_D = 5; push(LU); end
                1: begin MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 5; RA2_D = 5; PCSrc_E = 1; push(BR); end
                2: begin MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 15; RA1_D = 15; RA2_D = 15; push(NONE); end
                3: begin RegWrite_E = 1; WA3_E = 6; RA1_D = 6; push(FWD ? NONE : LU); end
                4: begin MemtoReg_E = 1; WA3_E = 5; RA1_D = 5; push(NONE); end
                default: begin PCSrc_E = 1; push(BR); end
            endcase
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL load_use[%0d]: got %h exp %h", i, got, expv);
            end
            next_cycle();
        end
    endtask

    task automatic test_dependency_stall();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            case (i)
                0: begin RegWrite_M = 1; WA3_M = 2; RA1_D = 2; push(FWD ? NONE : LU); end
                1: begin RegWrite_M = 1; WA3_M = 15; RA1_D = 15; push(NONE); end
                default: begin
                    RegWrite_M = 1; WA3_M = 9; RA2_D = 9; RA1_E = 9;
                    push(FWD ? mk_fwd(2'b10, 2'b00, 1'b0) : LU);
                end
            endcase
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL dep_stall[%0d]: got %h exp %h", i, got, expv);
            end
            next_cycle();
        end
    endtask

    // Start, MDone on the 7th BUSY cycle; branch + load-use during BUSY;
    // a start request in DONE must be dropped
    task automatic test_mcycle_done();
        for (int c = 0; c <= 10; c++) begin
            clear_inputs();
            if (c == 0) begin
                MStart_E = 1; push(NONE);
            end else if (c <= 7) begin
                if (c == 3) begin
                    PCSrc_E = 1; MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 5; RA1_D = 5;
                end
                if (c == 7) MDone = 1;
                push(BUSYV);
            end else begin
                if (c == 8) MStart_E = 1;
                push(NONE);
            end
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL mcycle_done[cyc %0d]: got %h exp %h", c, got, expv);
            end
            next_cycle();
        end
    endtask

    // No MDone: watchdog exit after 32 BUSY cycles. done_on_limit raises
    // MDone on the 32nd cycle, which must suppress MTimeout.
    task automatic test_timeout(input bit done_on_limit);
        for (int c = 0; c <= 34; c++) begin
            clear_inputs();
            if (c == 0) begin
                MStart_E = 1; push(NONE);
            end else if (c <= 32) begin
                if (c == 10) MStart_E = 1;
                if (c == 32 && done_on_limit) MDone = 1;
                push(BUSYV);
            end else if (c == 33) begin
                push(done_on_limit ? NONE : TOUT);
            end else begin
                push(NONE);
            end
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL timeout%0d[cyc %0d]: got %h exp %h",
                                   done_on_limit, c, got, expv);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_busy();
        for (int c = 0; c <= 3; c++) begin
            clear_inputs();
            if (c == 0) begin MStart_E = 1; push(NONE); end
            else push(BUSYV);
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL reset_busy[cyc %0d]: got %h exp %h", c, got, expv);
            end
            next_cycle();
        end
        // 4th BUSY cycle: reset acts without any clock edge
        PCSrc_E = 1; RegWrite_M = 1; WA3_M = 3; RA1_E = 3; RegWrite_W = 1; WA3_W = 7; RA2_M = 7;
        rst_p = 1;
        exp_cnt = 16'd0;
        push(NONE);
        #1;
        expv = sb.pop_front(); got = {obs, StallCount}; checks++;
        if (got !== expv) begin
            errors++; $display("FAIL reset_busy_async: got %h exp %h", got, expv);
        end
        next_cycle();
        clear_inputs();
        rst_p = 0;
        for (int c = 0; c < 2; c++) begin
            push(NONE);
            @(negedge clk);
            expv = sb.pop_front(); got = {obs, StallCount}; checks++;
            if (got !== expv) begin
                errors++; $display("FAIL reset_busy_release[%0d]: got %h exp %h", c, got, expv);
            end
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        MemtoReg_E = 1; RegWrite_E = 1; WA3_E = 5; RA1_D = 5;
        for (int n = 0; n < 65540; n++) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            @(posedge clk);
        end
        #1;
        push(LU);
        @(negedge clk);
        expv = sb.pop_front(); got = {obs, StallCount}; checks++;
        if (got !== expv) begin
            errors++; $display("FAIL stall_count_sat: got %h exp %h", got, expv);
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        rst_p   = 1;
        exp_cnt = 16'd0;
        clear_inputs();
        next_cycle();
        test_reset();
        test_forward();
        test_load_use();
        test_dependency_stall();
        test_mcycle_done();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_busy();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_MAX_CYCLES, default 32: multicycle-unit watchdog limit, in cycles.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_p  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports RA1_D, RA2_D  input  4 each  source register addresses in Decode.
REQ-005 The block SHALL have ports RA1_E, RA2_E  input  4 each  source register addresses in Execute.
REQ-006 The block SHALL have port RA2_M  input  4  store-data source register in Memory.
REQ-007 The block SHALL have ports WA3_E, WA3_M, WA3_W  input  4 each  destination register per stage.
REQ-008 The block SHALL have ports RegWrite_E, RegWrite_M, RegWrite_W  input  1 each  register-write enables per stage.
REQ-009 The block SHALL have port MemtoReg_E  input  1  Execute instruction is a load.
REQ-010 The block SHALL have port PCSrc_E  input  1  branch taken, resolved in Execute.
REQ-011 The block SHALL have ports MStart_E, MDone  input  1 each  multicycle op start; unit completion.
REQ-012 The block SHALL have ports StallF, StallD, StallE  output  1 each  hold the PC, F2D and D2E registers.
REQ-013 The block SHALL have ports FlushD, FlushE  output  1 each  refresh (clear) the F2D and D2E registers.
REQ-014 The block SHALL have ports ForwardAE, ForwardBE  output  2 each  operand selects: 00 = regfile, 01 = W result, 10 = M ALU result.
REQ-015 The block SHALL have ports ForwardM  output  1 (W result forwarded to store data), MBusy  output  1, MTimeout  output  1 (one-cycle pulse), StallCount  output  16.

Function
REQ-016 ForwardAE SHALL be 10 when RegWrite_M && WA3_M==RA1_E, else 01 when RegWrite_W && WA3_W==RA1_E, else 00; M SHALL have priority over W; ForwardBE SHALL use the same rule on RA2_E.
REQ-017 Address 15 (PC) SHALL never match for any forwarding or hazard comparison.
REQ-018 ForwardM SHALL be 1 when RegWrite_W && WA3_W==RA2_M.
REQ-019 Load-use: when MemtoReg_E && RegWrite_E && WA3_E matches RA1_D or RA2_D, the block SHALL assert StallF, StallD and FlushE combinationally in the same cycle.
REQ-020 When PCSrc_E=1, the block SHALL assert FlushD and FlushE; branch SHALL win over load-use (no StallF/StallD that cycle).
REQ-021 The multicycle FSM SHALL have states IDLE, BUSY and DONE.
REQ-022 FSM transitions SHALL be: IDLE->BUSY on MStart_E; BUSY->DONE on MDone or when the cycle counter reaches MC_MAX_CYCLES-1; DONE->IDLE unconditionally after one cycle.
REQ-023 In BUSY, the block SHALL assert StallF, StallD and StallE, and SHALL deassert FlushD and FlushE (stall dominates branch and load-use).
REQ-024 In DONE and IDLE, the block SHALL not assert any FSM stall, and the other rules SHALL apply.
REQ-025 The cycle counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-026 MTimeout SHALL pulse for the DONE cycle when exit was caused by the limit without MDone; MDone on the limit cycle SHALL suppress MTimeout.
REQ-027 MStart_E in BUSY or DONE SHALL be ignored.
REQ-028 MBusy SHALL equal (state==BUSY).
REQ-029 StallCount SHALL increment on every cycle with StallF=1 and saturate at 0xFFFF.

Reset
REQ-030 rst_p SHALL force the FSM to IDLE and clear the cycle counter and StallCount to 0, immediately and regardless of clk.
REQ-031 During reset, all outputs SHALL be 0, including mid-BUSY.

Configuration
REQ-032 With HAZARD_FWD_EN defined, forwarding SHALL operate per REQ-016 to REQ-018.
REQ-033 Without HAZARD_FWD_EN, ForwardAE, ForwardBE and ForwardM SHALL be constant 0, and any RegWrite_E or RegWrite_M destination matching RA1_D or RA2_D SHALL assert StallF, StallD and FlushE.

Structure
REQ-034 A shared package SHALL hold the forward-select encodings (FWD_RF, FWD_W, FWD_M), the FSM state enum and the PC register index constant 15.
REQ-035 One sub-module SHALL exist: mcycle_fsm, containing the FSM, cycle counter and MTimeout; the forwarding and hazard logic SHALL remain at top level.

Verification
REQ-036 With RegWrite_M=1, WA3_M=3, RA1_E=3, RegWrite_W=1, WA3_W=3 -> ForwardAE=10; with RegWrite_M=0 -> ForwardAE=01.
REQ-037 With MemtoReg_E=1, RegWrite_E=1, WA3_E=5, RA2_D=5 -> StallF=StallD=FlushE=1 for one cycle; with PCSrc_E also 1 -> FlushD=FlushE=1 and StallD=0.
REQ-038 MStart_E pulse, then MDone after 7 cycles -> MBusy=1 for 7 cycles, StallE=1 throughout, DONE for 1 cycle, MTimeout=0.
REQ-039 MStart_E with no MDone and MC_MAX_CYCLES=32 -> exit to DONE after 32 BUSY cycles with MTimeout=1 for one cycle.
REQ-040 rst_p asserted on the 4th BUSY cycle -> all outputs 0 immediately; IDLE after release.
REQ-041 Without HAZARD_FWD_EN, RegWrite_M=1, WA3_M=2, RA1_D=2 -> StallD=1 and ForwardAE=00; WA3_M=15, RA1_D=15 -> no stall.
